// File: rtl/matrix_bcd_writer.sv
// matrix_bcd_writer: accepts binary matrix elements over valid/ready, converts
// each to BCD with a bit-serial double-dabble, stores the digits in a back
// buffer and copies that buffer to the display digit bus during vblank.
module matrix_bcd_writer #(
  parameter int MATRIX_N = 3,
  parameter int MATRIX_M = 3,
  parameter int NUM_MAT  = 3,
  parameter int DIGITS   = 5,
  parameter int DATA_W   = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [DATA_W-1:0]                             in_data,
  input  logic                                          in_last,
  input  logic                                          vblank,
  output logic [MATRIX_N*NUM_MAT*MATRIX_M*DIGITS*4-1:0] bcd_out,
  output logic                                          frame_done,
  output logic                                          ovf,
  output logic [7:0]                                    frame_count
);

  localparam int TOTAL  = MATRIX_N * NUM_MAT * MATRIX_M;
  localparam int SLOT_W = 4 * DIGITS;
  // Nibbles needed to hold any DATA_W-bit value exactly: ceil(DATA_W/3.32)+1.
  localparam int DD_NIB = (DATA_W * 100 + 331) / 332 + 1;
  localparam int NIB    = (DIGITS > DD_NIB) ? DIGITS : DD_NIB;
  localparam int BCD_W  = 4 * NIB;
  localparam int PW     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CW     = $clog2(DATA_W + 1);

  localparam logic [PW-1:0] LAST_PTR  = PW'(TOTAL - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONV      = 2'd1,
    WRITE     = 2'd2,
    WAIT_SWAP = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;

  logic [CW-1:0]     step_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [BCD_W-1:0]  bcd_reg;
  logic [BCD_W-1:0]  bcd_adj;
  logic              last_reg;
  logic [PW-1:0]     wptr_reg;
  logic              ovf_pend_reg;
  logic [SLOT_W-1:0] back_mem [TOTAL];
  logic [SLOT_W-1:0] slot_word;
  logic              sat;
  logic              end_frame;

  logic              accept;
  logic              shift_en;
  logic              write_en;
  logic              swap_en;
  logic              ready_next;

  genvar gi;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 :
                                  bcd_reg[4*gi +: 4];
    end
  endgenerate

  // The conversion is exact, so any nonzero nibble above the displayed
  // digits means the value exceeds 10^DIGITS-1.
  generate
    if (NIB > DIGITS) begin : g_sat
      assign sat = |bcd_reg[BCD_W-1:SLOT_W];
    end else begin : g_nosat
      assign sat = 1'b0;
    end
  endgenerate

  // Slot layout puts the most significant digit in the lowest nibble.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_slot
      assign slot_word[4*gi +: 4] = sat ? 4'd9 : bcd_reg[4*(DIGITS-1-gi) +: 4];
    end
  endgenerate

  assign end_frame = (wptr_reg == LAST_PTR) || last_reg;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (in_valid && in_ready) state_next = CONV;
      CONV:      if (step_reg == LAST_STEP) state_next = WRITE;
      WRITE:     state_next = end_frame ? WAIT_SWAP : IDLE;
      WAIT_SWAP: if (vblank) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Per-state control strobes; ready is registered so it stays low in reset.
  always_comb begin
    accept   = 1'b0;
    shift_en = 1'b0;
    write_en = 1'b0;
    swap_en  = 1'b0;
    case (state_reg)
      IDLE:      accept   = in_valid & in_ready;
      CONV:      shift_en = 1'b1;
      WRITE:     write_en = 1'b1;
      WAIT_SWAP: swap_en  = vblank;
      default:   ;
    endcase
    ready_next = (state_next == IDLE);
  end

  // Capture an element and run one double-dabble step per CONV cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_reg  <= '0;
      shift_reg <= '0;
      bcd_reg   <= '0;
      last_reg  <= 1'b0;
    end else if (accept) begin
      step_reg  <= '0;
      shift_reg <= in_data;
      bcd_reg   <= '0;
      last_reg  <= in_last;
    end else if (shift_en) begin
      step_reg  <= step_reg + 1'b1;
      shift_reg <= shift_reg << 1;
      bcd_reg   <= (bcd_adj << 1) | BCD_W'(shift_reg[DATA_W-1]);
    end
  end

  // Back-buffer writes, write pointer and pending-overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_reg     <= '0;
      ovf_pend_reg <= 1'b0;
      for (int e = 0; e < TOTAL; e++) begin
        back_mem[e] <= '0;
      end
    end else begin
      if (write_en) begin
        back_mem[wptr_reg] <= slot_word;
        if (sat) ovf_pend_reg <= 1'b1;
        if (!end_frame) wptr_reg <= wptr_reg + 1'b1;
      end
      if (swap_en) begin
        wptr_reg     <= '0;
        ovf_pend_reg <= 1'b0;
      end
    end
  end

  // Display-facing registers: whole-frame copy and status on the swap edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready    <= 1'b0;
      bcd_out     <= '0;
      frame_done  <= 1'b0;
      ovf         <= 1'b0;
      frame_count <= '0;
    end else begin
      in_ready   <= ready_next;
      frame_done <= swap_en;
      if (swap_en) begin
        for (int e = 0; e < TOTAL; e++) begin
          bcd_out[e*SLOT_W +: SLOT_W] <= back_mem[e];
        end
        ovf         <= ovf_pend_reg;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_bcd_writer.sv
// Testbench for matrix_bcd_writer: an element-level reference model checked
// every cycle against the default build, directed literal checks, and a
// DIGITS=4 build for saturation.
module tb_matrix_bcd_writer;

  localparam int W     = 16;
  localparam int D     = 5;
  localparam int TOTAL = 27;
  localparam int BUS   = TOTAL * D * 4;
  localparam int BUS4  = TOTAL * 4 * 4;
  localparam int MAXV  = 99999;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            vblank = 1'b0;

  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic            in_last = 1'b0;
  logic [BUS-1:0]  bcd_out;
  logic            frame_done;
  logic            ovf;
  logic [7:0]      frame_count;

  logic            v4 = 1'b0;
  logic            r4;
  logic [W-1:0]    d4 = '0;
  logic            l4 = 1'b0;
  logic [BUS4-1:0] bcd4;
  logic            fd4;
  logic            ovf4;
  logic [7:0]      fc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_bcd_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .vblank(vblank), .bcd_out(bcd_out),
    .frame_done(frame_done), .ovf(ovf), .frame_count(frame_count)
  );

  matrix_bcd_writer #(.DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4),
    .in_data(d4), .in_last(l4), .vblank(vblank), .bcd_out(bcd4),
    .frame_done(fd4), .ovf(ovf4), .frame_count(fc4)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Reference model: elements as integers, a busy countdown per element,
  // and a displayed frame that is replaced wholesale on a swap.
  int m_back [TOTAL];
  int m_out  [TOTAL];
  int m_ready = 0, m_busy = 0, m_val = 0, m_last = 0, m_wptr = 0;
  int m_wait = 0, m_pend = 0, m_ovf = 0, m_fd = 0, m_fc = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int e = 0; e < TOTAL; e++) begin
        m_back[e] = 0;
        m_out[e]  = 0;
      end
      m_ready = 0; m_busy = 0; m_val = 0; m_last = 0; m_wptr = 0;
      m_wait = 0; m_pend = 0; m_ovf = 0; m_fd = 0; m_fc = 0;
    end else begin
      m_fd = 0;
      if (m_wait != 0) begin
        if (vblank) begin
          m_out  = m_back;
          m_ovf  = m_pend;
          m_pend = 0;
          m_fd   = 1;
          m_fc   = (m_fc + 1) % 256;
          m_wptr = 0;
          m_wait = 0;
          m_ready = 1;
        end
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_back[m_wptr] = (m_val > MAXV) ? MAXV : m_val;
          if (m_val > MAXV) m_pend = 1;
          if (m_wptr == TOTAL - 1 || m_last != 0) begin
            m_wait = 1;
            m_ready = 0;
          end else begin
            m_wptr++;
            m_ready = 1;
          end
        end
      end else if (in_valid && m_ready != 0) begin
        m_val   = int'(in_data);
        m_last  = int'(in_last);
        m_busy  = W + 1;
        m_ready = 0;
      end else begin
        m_ready = 1;
      end
    end
  end

  // Per-cycle comparison against the model, 3 time units after each edge.
  logic [BUS-1:0] exp_bus;
  initial forever begin
    @(posedge clk);
    #3;
    for (int e = 0; e < TOTAL; e++) begin
      for (int l = 0; l < D; l++) begin
        exp_bus[4*(e*D+l) +: 4] = 4'((m_out[e] / pow10(D - 1 - l)) % 10);
      end
    end
    chk_bus("bcd_out", bcd_out, exp_bus);
    chk("in_ready", int'(in_ready), m_ready);
    chk("frame_done", int'(frame_done), m_fd);
    chk("ovf", int'(ovf), m_ovf);
    chk("frame_count", int'(frame_count), m_fc);
  end

  task automatic send(input int v, input int last, input int which);
    int n = 0;
    @(negedge clk);
    if (which == 0) begin
      in_valid = 1'b1; in_data = W'(v); in_last = last[0];
    end else begin
      v4 = 1'b1; d4 = W'(v); l4 = last[0];
    end
    while (((which == 0) ? in_ready : r4) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_wait", int'(n < 100), 1);
    @(negedge clk);
    if (which == 0) begin
      in_valid = 1'b0; in_data = W'($urandom); in_last = 1'b1;
    end else begin
      v4 = 1'b0; d4 = W'($urandom); l4 = 1'b1;
    end
  endtask

  task automatic swap(input int which);
    int n = 0;
    logic seen = 1'b0;
    @(negedge clk);
    vblank = 1'b1;
    while (!seen && n < 100) begin
      @(posedge clk);
      #3;
      n++;
      seen = (which == 0) ? frame_done : fd4;
    end
    chk("swap_wait", int'(seen), 1);
    @(negedge clk);
    vblank = 1'b0;
  endtask

  initial begin
    int lowcnt;
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt;
    // Reset state and ready rising one edge after release.
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(in_ready), 0);
    chk_bus("rst_bcd", bcd_out, '0);
    chk("rst_fc", int'(frame_count), 0);
    reset = 1'b0;
    @(posedge clk); #3;
    chk("ready_after_rst", int'(in_ready), 1);

    // Single element 12345, vblank raised while still converting.
    send(12345, 1, 0);
    swap(0);
    chk("single_slot0", int'(bcd_out[19:0]), 'h54321);
    chk("single_rest", int'(bcd_out[BUS-1:20] == '0), 1);
    chk("single_fc", int'(frame_count), 1);

    // Full frame 0..26 back-to-back, valid held, data scrambled while busy.
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int k = 0; k < TOTAL; k++) begin
      lowcnt = 0;
      while (in_ready !== 1'b1 && lowcnt < 100) begin
        in_data = W'($urandom);
        @(negedge clk);
        lowcnt++;
      end
      if (k > 0) chk("ready_low_cycles", lowcnt, 17);
      in_data = W'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("full_wait_ready", int'(in_ready), 0);
    chk("full_unswapped", int'(bcd_out[19:0]), 'h54321);
    swap(0);
    chk("full_slot26", int'(bcd_out[4*26*D +: 20]), 'h62000);
    chk("full_slot13", int'(bcd_out[4*13*D +: 20]), 'h31000);
    chk("full_fc", int'(frame_count), 2);

    // Early in_last with vblank already high: only slot 0 changes.
    @(negedge clk);
    vblank = 1'b1;
    send(4321, 1, 0);
    swap(0);
    chk("early_slot0", int'(bcd_out[19:0]), 'h12340);
    chk("early_slot1", int'(bcd_out[39:20]), 'h10000);
    chk("early_fc", int'(frame_count), 3);

    // Reset during conversion of 777.
    send(777, 0, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_bus("midrst_bcd", bcd_out, '0);
    chk("midrst_fc", int'(frame_count), 0);
    chk("midrst_ready", int'(in_ready), 0);
    reset = 1'b0;
    @(posedge clk); #3;
    chk("midrst_ready_up", int'(in_ready), 1);
    send(55, 1, 0);
    swap(0);
    chk("post_rst_slot0", int'(bcd_out[19:0]), 'h55000);
    chk("post_rst_slot1", int'(bcd_out[39:20]), 0);
    chk("post_rst_fc", int'(frame_count), 1);

    // Saturation on the four-digit build.
    send(10000, 1, 1);
    swap(1);
    chk("sat_slot0", int'(bcd4[15:0]), 'h9999);
    chk("sat_ovf", int'(ovf4), 1);
    chk("sat_fc", int'(fc4), 1);
    send(9999, 1, 1);
    swap(1);
    chk("max_slot0", int'(bcd4[15:0]), 'h9999);
    chk("max_ovf", int'(ovf4), 0);
    send(42, 1, 1);
    swap(1);
    chk("small_slot0", int'(bcd4[15:0]), 'h2400);
    chk("small_ovf", int'(ovf4), 0);
    chk("small_fc", int'(fc4), 3);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
